// File: rtl/prog_timer.sv
// prog_timer: runtime-programmable one-shot / auto-reload delay and tick generator
//   clk, rst       clock and synchronous active-high reset
//   go, cycles     start request and period (cycles==0 ignored)
//   periodic       0 = one-shot, 1 = auto-reload; captured with go
//   pause, abort   hold the count / stop the run without expiry
//   busy, done     running / idle-or-final-one-shot-cycle level
//   expire         one-cycle pulse in the final cycle of every period
//   remaining      cycles left including the current one, 0 when idle
//   Optional macro PROG_TIMER_RESTART_EN: go with cycles!=0 during a run restarts it.
module prog_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] cycles,
  input  logic             periodic,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             expire,
  output logic [WIDTH-1:0] remaining
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [WIDTH-1:0] ONE = 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, per_q, per_d;
  logic mode_q, mode_d;
  logic run, load, restart, fin;
  assign run  = state_q == RUN;
  assign load = go && cycles != '0;
`ifdef PROG_TIMER_RESTART_EN
  assign restart = run && !abort && load;
`else
  assign restart = 1'b0;
`endif
  // final counting cycle: abort, restart and pause all suppress expiry
  assign fin       = run && !abort && !restart && !pause && cnt_q == '0;
  assign busy      = run;
  assign expire    = fin;
  assign done      = !run || (fin && !mode_q);
  assign remaining = run ? cnt_q + ONE : '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    mode_d  = mode_q;
    if ((!run && load) || restart) begin
      state_d = RUN;
      per_d   = cycles;
      mode_d  = periodic;
      cnt_d   = cycles - ONE;
    end else if (run && abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (fin) begin
      state_d = mode_q ? RUN : IDLE;
      cnt_d   = mode_q ? per_q - ONE : '0;
    end else if (run && !pause) begin
      cnt_d = cnt_q - ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
    end
  end
endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed scoreboard bench for prog_timer (WIDTH=16 and WIDTH=4 instances)
module tb_prog_timer;
  logic clk = 0, rst = 1, go16 = 0, go4 = 0, periodic = 0, pause = 0, abort = 0;
  logic [15:0] cycles = 0;
  logic busy16, done16, exp16, busy4, done4, exp4;
  logic [15:0] rem16;
  logic [3:0] rem4;
  logic sel4 = 0;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    string       name;
    logic        w4;
    logic [18:0] exp;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  prog_timer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .go(go16), .cycles(cycles), .periodic(periodic),
    .pause(pause), .abort(abort), .busy(busy16), .done(done16), .expire(exp16),
    .remaining(rem16)
  );
  prog_timer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .go(go4), .cycles(cycles[3:0]), .periodic(periodic),
    .pause(pause), .abort(abort), .busy(busy4), .done(done4), .expire(exp4),
    .remaining(rem4)
  );
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [18:0] act;
      e = q.pop_front();
      act = e.w4 ? {busy4, done4, exp4, 12'b0, rem4} : {busy16, done16, exp16, rem16};
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got busy/done/expire/rem=%b/%b/%b/%0d required %b/%b/%b/%0d",
                 e.name, act[18], act[17], act[16], act[15:0],
                 e.exp[18], e.exp[17], e.exp[16], e.exp[15:0]);
      end
    end
  end
  task automatic step(input string l, input logic r, g, input logic [15:0] c,
                      input logic pe, pa, ab, eb, ed, ee, input logic [15:0] er);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; go16 = g & !sel4; go4 = g & sel4; cycles = c;
    periodic = pe; pause = pa; abort = ab;
    e.name = l; e.w4 = sel4; e.exp = {eb, ed, ee, er};
    q.push_back(e);
  endtask
  task automatic idle(input string l);
    step(l, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask
  task automatic idle_go(input string l, input logic [15:0] c, input logic pe);
    step(l, 0, 1, c, pe, 0, 0, 0, 1, 0, 0);
  endtask
  task automatic run(input string l, input logic pa, ab, ed, ee, input logic [15:0] er);
    step(l, 0, 0, 0, 0, pa, ab, 1, ed, ee, er);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    idle("reset");
    idle_go("os5_go", 5, 0);
    for (int i = 1; i <= 5; i++) run("os5_run", 0, 0, i == 5, i == 5, 16'(6 - i));
    idle("os5_idle");
    idle_go("per3_go", 3, 1);
    for (int i = 1; i <= 12; i++) run("per3_run", 0, 0, 0, i % 3 == 0, 16'(3 - (i - 1) % 3));
    run("per3_abort", 0, 1, 0, 0, 3);
    idle("per3_idle");
    idle("per3_idle2");
    idle_go("pause_go", 4, 0);
    run("pause_c1", 0, 0, 0, 0, 4);
    for (int i = 2; i <= 4; i++) run("pause_hold", 1, 0, 0, 0, 3);
    run("pause_c5", 0, 0, 0, 0, 3);
    run("pause_c6", 0, 0, 0, 0, 2);
    run("pause_c7", 0, 0, 1, 1, 1);
    idle("pause_idle");
    idle_go("pfin_go", 2, 0);
    run("pfin_c1", 0, 0, 0, 0, 2);
    run("pfin_hold", 1, 0, 0, 0, 1);
    run("pfin_hold2", 1, 0, 0, 0, 1);
    run("pfin_exp", 0, 0, 1, 1, 1);
    idle("pfin_idle");
    idle_go("zero_go", 0, 0);
    idle("zero_idle");
    idle_go("one_go", 1, 0);
    run("one_run", 0, 0, 1, 1, 1);
    idle_go("one_regő", 1, 0);
    run("one_run2", 0, 0, 1, 1, 1);
    idle("one_idle");
    idle_go("p1_go", 1, 1);
    for (int i = 0; i < 3; i++) run("p1_run", 0, 0, 0, 1, 1);
    run("p1_abort", 0, 1, 0, 0, 1);
    idle("p1_idle");
    idle_go("abexp_go", 2, 0);
    run("abexp_c1", 0, 0, 0, 0, 2);
    run("abexp_abort", 0, 1, 0, 0, 1);
    idle("abexp_idle");
    idle_go("abpause_go", 3, 0);
    run("abpause", 1, 1, 0, 0, 3);
    idle("abpause_idle");
    idle_go("rst_go", 5, 1);
    run("rst_c1", 0, 0, 0, 0, 5);
    step("rst_c2", 1, 0, 0, 0, 0, 0, 1, 0, 0, 4);
    idle("rst_after");
    idle("rst_after2");
    sel4 = 1;
    idle_go("w4_go", 15, 0);
    for (int i = 1; i <= 15; i++) run("w4_run", 0, 0, i == 15, i == 15, 16'(16 - i));
    idle("w4_idle");
    sel4 = 0;
    idle_go("rs_go", 3, 0);
    run("rs_c1", 0, 0, 0, 0, 3);
    step("rs_c2", 0, 1, 6, 0, 0, 0, 1, 0, 0, 2);
`ifdef PROG_TIMER_RESTART_EN
    for (int i = 3; i <= 8; i++) run("rs_run", 0, 0, i == 8, i == 8, 16'(9 - i));
    idle("rs_idle");
`else
    run("rs_c3", 0, 0, 1, 1, 1);
    for (int i = 4; i <= 9; i++) idle("rs_idle");
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
